// File: rtl/wb_port_arbiter_if.sv
// Bus bundle for wb_port_arbiter: pipeline writeback, MDU result offer,
// register-file write port, hazard lookup and hold request.
interface wb_port_arbiter_if #(parameter int DEPTH = 2);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          wb_valid;
  logic [4:0]    wb_rd;
  logic [31:0]   wb_data;
  logic          mdu_valid;
  logic [4:0]    mdu_rd;
  logic [31:0]   mdu_data;
  logic          mdu_ready;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [31:0]   rf_wdata;
  logic          pipe_hold;
  logic [4:0]    chk_rd;
  logic          chk_hit;
  logic [CW-1:0] q_count;

  modport slave (
    input  wb_valid, wb_rd, wb_data, mdu_valid, mdu_rd, mdu_data, chk_rd,
    output mdu_ready, rf_we, rf_waddr, rf_wdata, pipe_hold, chk_hit, q_count
  );

  modport master (
    output wb_valid, wb_rd, wb_data, mdu_valid, mdu_rd, mdu_data, chk_rd,
    input  mdu_ready, rf_we, rf_waddr, rf_wdata, pipe_hold, chk_hit, q_count
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline WB has priority, MDU results queue in FIFO order.
// Optional anti-starvation hold request enabled by defining WB_ARB_AGING_EN.
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst,
  wb_port_arbiter_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic        live;
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t        q_q [DEPTH];
  entry_t        q_d [DEPTH];
  logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rf_we_q, rf_we_d;
  logic [4:0]    rf_waddr_q, rf_waddr_d;
  logic [31:0]   rf_wdata_q, rf_wdata_d;

  logic full, wb_gnt, q_gnt, push, hit;

  assign full   = (cnt_q == CW'(DEPTH));
  assign wb_gnt = bus.wb_valid && (bus.wb_rd != 5'd0);
  assign q_gnt  = !wb_gnt && (cnt_q != '0);
  assign push   = bus.mdu_valid && !full && (bus.mdu_rd != 5'd0);

  always_comb begin
    q_d        = q_q;
    rptr_d     = rptr_q;
    wptr_d     = wptr_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (wb_gnt) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = bus.wb_rd;
      rf_wdata_d = bus.wb_data;
      // Queued results are older than this WB value, so they must never land on top of it.
      for (int i = 0; i < DEPTH; i++)
        if (q_q[i].rd == bus.wb_rd) q_d[i].live = 1'b0;
    end else if (q_gnt) begin
      rf_we_d         = q_q[rptr_q].live;
      rf_waddr_d      = q_q[rptr_q].rd;
      rf_wdata_d      = q_q[rptr_q].data;
      q_d[rptr_q].live = 1'b0;
      rptr_d          = rptr_q + 1'b1;
    end
    // Push after the kill loop: a same-edge enqueue is younger and stays live.
    if (push) begin
      q_d[wptr_q] = '{live: 1'b1, rd: bus.mdu_rd, data: bus.mdu_data};
      wptr_d      = wptr_q + 1'b1;
    end
    cnt_d = cnt_q + CW'(push) - CW'(q_gnt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) q_q[i] <= '0;
      rptr_q     <= '0;
      wptr_q     <= '0;
      cnt_q      <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      q_q        <= q_d;
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      cnt_q      <= cnt_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (q_q[i].live && (q_q[i].rd == bus.chk_rd)) hit = 1'b1;
  end

`ifdef WB_ARB_AGING_EN
  logic [3:0] age_q, age_d;
  logic       hold_q, hold_d;

  always_comb begin
    hold_d = 1'b0;
    age_d  = age_q;
    if (cnt_q == '0 || q_gnt) age_d = 4'd0;
    else if (wb_gnt)          age_d = age_q + 4'd1;
    if (age_d == 4'(STARVE_LIMIT)) begin
      hold_d = 1'b1;
      age_d  = 4'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age_q  <= 4'd0;
      hold_q <= 1'b0;
    end else begin
      age_q  <= age_d;
      hold_q <= hold_d;
    end
  end

  assign bus.pipe_hold = hold_q;
`else
  logic unused_starve_limit;
  assign unused_starve_limit = ^4'(STARVE_LIMIT);
  assign bus.pipe_hold       = 1'b0;
`endif

  assign bus.mdu_ready = !full;
  assign bus.chk_hit   = hit && (bus.chk_rd != 5'd0);
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.q_count   = cnt_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_wb_port_arbiter;
  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;
  localparam int CW           = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.DEPTH(DEPTH)) bus();
  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct { bit live; bit [4:0] rd; bit [31:0] data; } ent_t;
  ent_t      mq[$];
  bit        exp_we;
  bit [4:0]  exp_waddr;
  bit [31:0] exp_wdata;
  bit        exp_hold;
`ifdef WB_ARB_AGING_EN
  int        age;
`endif

  function automatic bit model_hit(bit [4:0] r);
    foreach (mq[i]) if (mq[i].live && mq[i].rd == r && r != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Advance the reference model by one edge using the inputs currently driven.
  task automatic model_step();
    bit   full, wbg;
    ent_t e;
    full = (mq.size() == DEPTH);
    wbg  = bus.wb_valid && bus.wb_rd != 0;
`ifdef WB_ARB_AGING_EN
    if (mq.size() == 0 || !wbg) age = 0; else age++;
    exp_hold = (age == STARVE_LIMIT);
    if (exp_hold) age = 0;
`else
    exp_hold = 1'b0;
`endif
    if (wbg) begin
      exp_we = 1'b1; exp_waddr = bus.wb_rd; exp_wdata = bus.wb_data;
      foreach (mq[i]) if (mq[i].rd == bus.wb_rd) mq[i].live = 1'b0;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      exp_we = e.live; exp_waddr = e.rd; exp_wdata = e.data;
    end else begin
      exp_we = 1'b0;
    end
    if (bus.mdu_valid && !full && bus.mdu_rd != 0) mq.push_back('{1'b1, bus.mdu_rd, bus.mdu_data});
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wb_valid = 0; bus.wb_rd = 0; bus.wb_data = 0;
    bus.mdu_valid = 0; bus.mdu_rd = 0; bus.mdu_data = 0;
    bus.chk_rd = 0;
  endtask

  task automatic model_reset();
    mq.delete(); exp_we = 0; exp_waddr = 0; exp_wdata = 0; exp_hold = 0;
`ifdef WB_ARB_AGING_EN
    age = 0;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    #1;
    checks++; if (bus.rf_we !== 1'b0)       begin errors++; $display("FAIL reset_rf_we got %0b want 0", bus.rf_we); end
    checks++; if (bus.rf_waddr !== 5'd0)    begin errors++; $display("FAIL reset_rf_waddr got %0d want 0", bus.rf_waddr); end
    checks++; if (bus.rf_wdata !== 32'd0)   begin errors++; $display("FAIL reset_rf_wdata got %0h want 0", bus.rf_wdata); end
    checks++; if (bus.pipe_hold !== 1'b0)   begin errors++; $display("FAIL reset_pipe_hold got %0b want 0", bus.pipe_hold); end
    checks++; if (bus.q_count !== CW'(0))   begin errors++; $display("FAIL reset_q_count got %0d want 0", bus.q_count); end
    checks++; if (bus.mdu_ready !== 1'b1)   begin errors++; $display("FAIL reset_mdu_ready got %0b want 1", bus.mdu_ready); end
  endtask

  task automatic test_mdu_basic();
    bus.mdu_valid = 1; bus.mdu_rd = 5; bus.mdu_data = 32'h1234;
    #1;
    checks++; if (bus.mdu_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got %0b want 1", bus.mdu_ready); end
    tick();
    idle_inputs();
    checks++; if (bus.q_count !== CW'(1)) begin errors++; $display("FAIL basic_qcount1 got %0d want 1", bus.q_count); end
    checks++; if (bus.rf_we !== 1'b0)     begin errors++; $display("FAIL basic_we_early got %0b want 0", bus.rf_we); end
    tick();
    checks++; if (bus.rf_we !== 1'b1)          begin errors++; $display("FAIL basic_we got %0b want 1", bus.rf_we); end
    checks++; if (bus.rf_waddr !== 5'd5)       begin errors++; $display("FAIL basic_waddr got %0d want 5", bus.rf_waddr); end
    checks++; if (bus.rf_wdata !== 32'h1234)   begin errors++; $display("FAIL basic_wdata got %0h want 1234", bus.rf_wdata); end
    checks++; if (bus.q_count !== CW'(0))      begin errors++; $display("FAIL basic_qcount0 got %0d want 0", bus.q_count); end
  endtask

  task automatic test_waw_kill();
    bus.wb_valid = 1; bus.wb_rd = 9; bus.wb_data = 32'h99;
    bus.mdu_valid = 1; bus.mdu_rd = 3; bus.mdu_data = 32'hAAAA;
    tick();
    bus.mdu_rd = 4; bus.mdu_data = 32'hBBBB;
    tick();
    bus.mdu_valid = 0; bus.chk_rd = 3; #1;
    checks++; if (bus.q_count !== CW'(2)) begin errors++; $display("FAIL waw_qcount2 got %0d want 2", bus.q_count); end
    checks++; if (bus.mdu_ready !== 1'b0) begin errors++; $display("FAIL waw_full_ready got %0b want 0", bus.mdu_ready); end
    checks++; if (bus.chk_hit !== 1'b1)   begin errors++; $display("FAIL waw_hit_before got %0b want 1", bus.chk_hit); end
    bus.wb_rd = 3; bus.wb_data = 32'h1111;
    tick();
    bus.wb_valid = 0; bus.chk_rd = 3; #1;
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd3 || bus.rf_wdata !== 32'h1111)
      begin errors++; $display("FAIL waw_wb_write got we=%0b %0d/%0h want 1 3/1111", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    checks++; if (bus.chk_hit !== 1'b0) begin errors++; $display("FAIL waw_hit3_after got %0b want 0", bus.chk_hit); end
    bus.chk_rd = 4; #1;
    checks++; if (bus.chk_hit !== 1'b1) begin errors++; $display("FAIL waw_hit4 got %0b want 1", bus.chk_hit); end
    tick();
    checks++; if (bus.rf_we !== 1'b0)     begin errors++; $display("FAIL waw_dead_pop got %0b want 0", bus.rf_we); end
    checks++; if (bus.q_count !== CW'(1)) begin errors++; $display("FAIL waw_qcount1 got %0d want 1", bus.q_count); end
    tick();
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd4 || bus.rf_wdata !== 32'hBBBB)
      begin errors++; $display("FAIL waw_live_pop got we=%0b %0d/%0h want 1 4/bbbb", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    idle_inputs();
  endtask

  task automatic test_full_backpressure();
    int        idx = 0;
    bit        acc;
    bit [36:0] got[$];
    bus.wb_valid = 1; bus.wb_rd = 7;
    for (int c = 0; c < 6; c++) begin
      bus.wb_data = $urandom;
      bus.mdu_valid = (idx < 3); bus.mdu_rd = 5'(10 + idx); bus.mdu_data = 32'hA0 + 32'(idx);
      #1; acc = bus.mdu_valid && bus.mdu_ready;
      tick();
      if (acc) idx++;
    end
    checks++; if (idx != 2)               begin errors++; $display("FAIL full_accepts got %0d want 2", idx); end
    checks++; if (bus.q_count !== CW'(2)) begin errors++; $display("FAIL full_qcount got %0d want 2", bus.q_count); end
    checks++; if (bus.mdu_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0b want 0", bus.mdu_ready); end
    checks++; if (bus.rf_waddr !== 5'd7)  begin errors++; $display("FAIL full_wb_addr got %0d want 7", bus.rf_waddr); end
    bus.wb_valid = 0;
    for (int c = 0; c < 10 && got.size() < 3; c++) begin
      bus.mdu_valid = (idx < 3); bus.mdu_rd = 5'(10 + idx); bus.mdu_data = 32'hA0 + 32'(idx);
      #1; acc = bus.mdu_valid && bus.mdu_ready;
      tick();
      if (acc) idx++;
      if (bus.rf_we) got.push_back({bus.rf_waddr, bus.rf_wdata});
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== {5'(10 + i), 32'hA0 + 32'(i)}) begin
        errors++; $display("FAIL full_order[%0d] got %0h want %0h (writes seen %0d)", i,
                           (i < got.size()) ? got[i] : 37'h0, {5'(10 + i), 32'hA0 + 32'(i)}, got.size());
      end
    end
    idle_inputs();
  endtask

  task automatic test_rd_zero();
    bus.wb_valid = 1; bus.wb_rd = 0; bus.wb_data = 32'hDEAD;
    bus.mdu_valid = 1; bus.mdu_rd = 0; bus.mdu_data = 32'hBEEF;
    #1;
    checks++; if (bus.mdu_ready !== 1'b1) begin errors++; $display("FAIL rd0_ready got %0b want 1", bus.mdu_ready); end
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if (bus.q_count !== CW'(0)) begin errors++; $display("FAIL rd0_qcount got %0d want 0", bus.q_count); end
      checks++; if (bus.rf_we !== 1'b0)     begin errors++; $display("FAIL rd0_we got %0b want 0", bus.rf_we); end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    bus.wb_valid = 1; bus.wb_rd = 9; bus.wb_data = 32'h55;
    bus.mdu_valid = 1; bus.mdu_rd = 20; bus.mdu_data = 32'h2020;
    tick();
    bus.mdu_rd = 21; bus.mdu_data = 32'h2121;
    tick();
    checks++; if (bus.q_count !== CW'(2)) begin errors++; $display("FAIL rstmid_pre_qcount got %0d want 2", bus.q_count); end
    idle_inputs();
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.rf_we !== 1'b0 || bus.rf_waddr !== 5'd0 || bus.rf_wdata !== 32'd0 || bus.pipe_hold !== 1'b0)
      begin errors++; $display("FAIL rstmid_rf got we=%0b %0d/%0h hold=%0b want 0 0/0 0", bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.pipe_hold); end
    checks++; if (bus.q_count !== CW'(0) || bus.mdu_ready !== 1'b1)
      begin errors++; $display("FAIL rstmid_queue got cnt=%0d ready=%0b want 0 1", bus.q_count, bus.mdu_ready); end
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (bus.rf_we !== 1'b0 || bus.q_count !== CW'(0))
        begin errors++; $display("FAIL rstmid_post[%0d] got we=%0b cnt=%0d want 0 0", c, bus.rf_we, bus.q_count); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bus.wb_valid  = ($urandom_range(0, 3) != 0) && !bus.pipe_hold;
      bus.wb_rd     = 5'($urandom_range(0, 7));
      bus.wb_data   = $urandom;
      bus.mdu_valid = $urandom_range(0, 1);
      bus.mdu_rd    = 5'($urandom_range(0, 7));
      bus.mdu_data  = $urandom;
      bus.chk_rd    = 5'($urandom_range(0, 7));
      #1;
      checks++; if (bus.mdu_ready !== (mq.size() != DEPTH))
        begin errors++; $display("FAIL rnd_ready c=%0d got %0b want %0b", c, bus.mdu_ready, mq.size() != DEPTH); end
      checks++; if (bus.chk_hit !== model_hit(bus.chk_rd))
        begin errors++; $display("FAIL rnd_chk_hit c=%0d rd=%0d got %0b want %0b", c, bus.chk_rd, bus.chk_hit, model_hit(bus.chk_rd)); end
      tick();
      checks++; if (bus.rf_we !== exp_we || (exp_we && (bus.rf_waddr !== exp_waddr || bus.rf_wdata !== exp_wdata)))
        begin errors++; $display("FAIL rnd_write c=%0d got %0b %0d/%0h want %0b %0d/%0h", c, bus.rf_we, bus.rf_waddr, bus.rf_wdata, exp_we, exp_waddr, exp_wdata); end
      checks++; if (bus.q_count !== CW'(mq.size()))
        begin errors++; $display("FAIL rnd_qcount c=%0d got %0d want %0d", c, bus.q_count, mq.size()); end
      checks++; if (bus.pipe_hold !== exp_hold)
        begin errors++; $display("FAIL rnd_hold c=%0d got %0b want %0b", c, bus.pipe_hold, exp_hold); end
    end
    idle_inputs();
    repeat (DEPTH + 2) tick();
  endtask

  task automatic test_starvation();
    bus.wb_valid = 1; bus.wb_rd = 7; bus.wb_data = 32'h77;
    bus.mdu_valid = 1; bus.mdu_rd = 15; bus.mdu_data = 32'hCAFE;
    tick();
    bus.mdu_valid = 0;
`ifdef WB_ARB_AGING_EN
    for (int k = 1; k <= STARVE_LIMIT; k++) begin
      tick();
      checks++; if (bus.pipe_hold !== (k == STARVE_LIMIT))
        begin errors++; $display("FAIL aging_hold k=%0d got %0b want %0b", k, bus.pipe_hold, k == STARVE_LIMIT); end
    end
`else
    for (int k = 1; k <= 2 * STARVE_LIMIT; k++) begin
      tick();
      checks++; if (bus.pipe_hold !== 1'b0) begin errors++; $display("FAIL noaging_hold k=%0d got %0b want 0", k, bus.pipe_hold); end
    end
    checks++; if (bus.q_count !== CW'(1)) begin errors++; $display("FAIL noaging_qcount got %0d want 1", bus.q_count); end
`endif
    bus.wb_valid = 0;
    tick();
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd15 || bus.rf_wdata !== 32'hCAFE)
      begin errors++; $display("FAIL starve_write got we=%0b %0d/%0h want 1 15/cafe", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    checks++; if (bus.pipe_hold !== 1'b0 || bus.q_count !== CW'(0))
      begin errors++; $display("FAIL starve_after got hold=%0b cnt=%0d want 0 0", bus.pipe_hold, bus.q_count); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_mdu_basic();
    test_waw_kill();
    test_full_backpressure();
    test_rd_zero();
    test_reset_mid();
    test_random();
    test_starvation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbitrates the single register-file write port between the in-order pipeline writeback (ALU/memory result) and the multi-cycle multiply/divide unit (MDU). Pipeline writeback always wins. MDU results wait in a small in-order queue until the port is idle. Also provides write-after-write (WAW) cancellation, a pending-destination lookup for the hazard unit, and an optional anti-starvation hold request. Sits between the WB-stage write-data select and the register file.

## Interface
- DEPTH, 2, MDU result queue depth; power of two, 2..8
- STARVE_LIMIT, 4, cycles a queue head may be denied before a hold is requested; 1..15
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- wb_valid  in  1  pipeline writeback valid this cycle
- wb_rd  in  5  pipeline destination register
- wb_data  in  32  pipeline writeback data (already selected ALU/memory)
- mdu_valid  in  1  MDU result offered
- mdu_rd  in  5  MDU destination register
- mdu_data  in  32  MDU result
- mdu_ready  out  1  queue can accept; combinational, equals not-full
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  5  register-file write address (registered)
- rf_wdata  out  32  register-file write data (registered)
- pipe_hold  out  1  request upstream to insert one WB bubble (registered)
- chk_rd  in  5  register number queried by the hazard unit
- chk_hit  out  1  combinational; a live queued entry targets chk_rd (chk_rd != 0)
- q_count  out  log2(DEPTH)+1  current queue occupancy

## Operation
- Queue entry fields: live bit, rd, data. Circular FIFO with read pointer, write pointer and count.
- Enqueue: mdu_valid && mdu_ready at a posedge. If mdu_rd == 0, the handshake completes but nothing is enqueued.
- Grant, evaluated each cycle:
  - WB grant if wb_valid && wb_rd != 0.
  - Otherwise queue grant if count > 0.
  - Otherwise idle.
- WB grant: rf_we<=1, rf_waddr<=wb_rd, rf_wdata<=wb_data. The queue is not popped.
- Queue grant: pop the head. rf_we<=head.live, with rd/data from the head. A dead head pops with rf_we=0.
- Idle: rf_we<=0. rf_waddr and rf_wdata hold their values.
- WAW kill: on a WB grant, every queued entry with rd == wb_rd has its live bit cleared at the same edge. The queued result is older, so the pipeline value must survive.
- An entry enqueued at the same edge as a WB grant to the same rd is NOT killed. The MDU result is younger.
- Full queue: mdu_ready=0 even if a pop occurs that cycle. No same-cycle pop/push when full.
- chk_hit ignores the incoming mdu_* value; it covers queued entries only.

## Timing
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, pipe_hold=0, q_count=0, all live bits 0, pointers 0, age counter 0. mdu_ready=1 after reset.
- Reset asserted mid-operation discards all queued entries. No pending write is issued after reset release.
- WB path latency: 1 cycle (inputs at edge N, rf_* valid after edge N).
- MDU path minimum latency: 2 cycles (enqueue at edge N, written at edge N+1 if the port is idle).
- Queue order is strict FIFO.
- Pointers wrap modulo DEPTH.
- q_count ranges 0..DEPTH.

## Configuration
- WB_ARB_AGING_EN defined:
  - A 4-bit age counter increments on each cycle the queue is non-empty and a WB grant occurs.
  - It clears on any queue grant and whenever the queue is empty.
  - When it reaches STARVE_LIMIT, pipe_hold<=1 for exactly one cycle and the counter clears.
  - Upstream contract: wb_valid=0 in the cycle after pipe_hold is high, so the head is granted then.
- WB_ARB_AGING_EN undefined:
  - No age counter; pipe_hold is constant 0.
  - MDU results may wait indefinitely under continuous WB traffic.

## Test plan
- Reset, then MDU offers rd=5, data=0x1234 with WB idle -> mdu_ready=1; rf_we=1, rf_waddr=5, rf_wdata=0x1234 one edge after enqueue; q_count returns 0.
- Enqueue rd=3/0xAAAA and rd=4/0xBBBB, then WB writes rd=3/0x1111 -> WB write 3/0x1111 occurs; the 3/0xAAAA pop has rf_we=0; 4/0xBBBB is written next; chk_hit(3)=0 after the kill.
- DEPTH=2 with continuous WB rd=7 traffic and three MDU offers -> mdu_ready=0 after two accepts; third offer is held; q_count=2; no entry is lost.
- With WB_ARB_AGING_EN, STARVE_LIMIT=4, one queued entry and continuous WB traffic -> pipe_hold high for exactly 1 cycle after 4 denied cycles; the entry is written during the resulting bubble.
- MDU offers rd=0 and WB offers rd=0 -> handshake completes; q_count stays 0; rf_we stays 0.
- Assert rst while q_count=2 -> all outputs return to reset values; no queued write appears after rst deasserts.
